// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the DMEM load/store unit: access sizes, FSM states,
// DMEM geometry and address alignment helpers.
package dmem_lsu_pkg;

   localparam int DMEM_ADDR_W = 13;
   localparam int BANK_W      = 3;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_RESP
   } state_t;

   // Size 3 falls into the default arm and behaves as a word.
   function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: return lo;
         SZ_HALF: return {lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lo[0];
         default: return |lo;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane steering between a 32-bit DMEM word and byte/half/word accesses:
// little-endian load extract with sign/zero extension, and store lane merge.
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [1:0]  lane,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_word
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = rword[{lane, 3'b000} +: 8];
      half_v     = rword[{lane[1], 4'b0000} +: 16];
      load_data  = rword;
      merge_word = wdata;
      case (size)
         SZ_BYTE: begin
            load_data  = {{24{sgn & byte_v[7]}}, byte_v};
            merge_word = rword;
            merge_word[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data  = {{16{sgn & half_v[15]}}, half_v};
            merge_word = rword;
            merge_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of DMEM: one request at a time, sub-word stores as
// read-modify-write. DMEM_LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
)
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [1:0]             req_size,
   input  logic                   req_signed,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_error,
   output logic [DMEM_ADDR_W-1:0] dmem_address,
   output logic [DATA_W-1:0]      dmem_data_in,
   output logic                   dmem_read_write,
   input  logic [DATA_W-1:0]      dmem_dataOut
);

   state_t              state_q, state_d;
   logic                accept, trap;
   logic                lat_write, lat_signed;
   logic [1:0]          lat_size;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [DATA_W-1:0]   ld_data, mg_word;

   assign accept = req_valid && (state_q == ST_IDLE);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   logic error_q;
   assign trap = is_misaligned(req_size, req_addr[1:0]);
   always_ff @(posedge clock or posedge reset)
      if (reset)       error_q <= 1'b0;
      else if (accept) error_q <= trap;
   assign rsp_error = error_q;
`else
   assign trap      = 1'b0;
   assign rsp_error = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset)
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (accept) begin
               if (trap)                        state_d = ST_RESP;
               else if (req_write && req_size[1]) state_d = ST_WR;
               else                             state_d = ST_RD;
            end
         ST_RD:   state_d = ST_CAP;
         ST_CAP:  state_d = lat_write ? ST_WR : ST_RESP;
         ST_WR:   state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Decoded straight from the state so reset drops a pending write at once.
   always_comb begin
      req_ready       = (state_q == ST_IDLE);
      rsp_valid       = (state_q == ST_RESP);
      dmem_read_write = (state_q == ST_WR);
   end

   // wdata_q doubles as the DMEM write word: raw store data, later the merge.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         lat_write  <= 1'b0;
         lat_signed <= 1'b0;
         lat_size   <= SZ_BYTE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE:
               if (accept) begin
                  lat_write  <= req_write;
                  lat_signed <= req_signed;
                  lat_size   <= req_size;
                  addr_q     <= {req_addr[ADDR_W-1:2], align_lo(req_size, req_addr[1:0])};
                  wdata_q    <= req_wdata;
                  rdata_q    <= '0;
               end
            ST_CAP:
               if (lat_write) wdata_q <= mg_word;
               else           rdata_q <= ld_data;
            default: ;
         endcase
      end

   dmem_lsu_align u_align (
      .size       (lat_size),
      .sgn        (lat_signed),
      .lane       (addr_q[1:0]),
      .rword      (dmem_dataOut),
      .wdata      (wdata_q),
      .load_data  (ld_data),
      .merge_word (mg_word)
   );

   assign dmem_address = addr_q[ADDR_W-1:2];
   assign dmem_data_in = wdata_q;
   assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized scoreboard bench for dmem_lsu against a byte-addressed memory model
// and a one-cycle-latency DMEM stand-in.
module tb_dmem_lsu;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clock = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [14:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_ready = 1'b1;
   logic        req_ready, rsp_valid, rsp_error, dmem_read_write;
   logic [31:0] rsp_rdata, dmem_data_in;
   logic [31:0] dmem_dataOut = '0;
   logic [12:0] dmem_address;

   dmem_lsu dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .dmem_address(dmem_address),
      .dmem_data_in(dmem_data_in), .dmem_read_write(dmem_read_write),
      .dmem_dataOut(dmem_dataOut)
   );

   always #5 clock = ~clock;

   // DMEM stand-in: synchronous read, one cycle latency.
   bit [31:0] dm [8192];
   always @(posedge clock) begin
      if (dmem_read_write) dm[dmem_address] <= dmem_data_in;
      dmem_dataOut <= dm[dmem_address];
   end

   typedef struct packed {
      logic [31:0] rd;
      logic        er;
      logic [3:0]  lat;
      logic [3:0]  nwr;
      logic [12:0] wa;
   } exp_t;

   exp_t        exp_q[$];
   bit [7:0]    rmem [32768];
   int          total = 0, bad = 0;
   int          cyc = 0, acc_cyc = 0, wr_cnt = 0;
   bit          active = 1'b0;
   logic [31:0] last_rdata;
   logic        last_err;
   int          rr_mode = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // rsp_ready pattern: 0 always ready, 1 random, 2 hold low for 5 response cycles.
   initial begin
      int held = 0;
      forever begin
         @(posedge clock); #1;
         case (rr_mode)
            1: rsp_ready = 1'($urandom_range(0, 1));
            2: begin
               if (rsp_valid) held++;
               rsp_ready = (held > 5);
            end
            default: rsp_ready = 1'b1;
         endcase
         if (rr_mode != 2) held = 0;
      end
   end

   // Monitor: compares every DUT response and DMEM write against the queue head.
   always @(negedge clock) begin
      if (reset) begin
         active = 1'b0;
      end else begin
         if (req_valid && req_ready) begin
            acc_cyc = cyc;
            wr_cnt  = 0;
         end
         if (dmem_read_write) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("wr_unexpected", {19'd0, dmem_address}, 32'hFFFF_FFFF);
            else                   chk("wr_addr", {19'd0, dmem_address}, {19'd0, exp_q[0].wa});
         end
         if (rsp_valid) begin
            chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            chk("write_in_resp", {31'd0, dmem_read_write}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
               chk("rsp_rdata", rsp_rdata, exp_q[0].rd);
               chk("rsp_error", {31'd0, rsp_error}, {31'd0, exp_q[0].er});
               if (!active) begin
                  chk("latency", cyc - acc_cyc, {28'd0, exp_q[0].lat});
                  chk("write_count", wr_cnt, {28'd0, exp_q[0].nwr});
                  last_rdata = rsp_rdata;
                  last_err   = rsp_error;
                  active     = 1'b1;
               end
               if (rsp_ready) begin
                  active = 1'b0;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Issue one request; the expected response comes from the byte-level model.
   task automatic do_req(input bit w, input bit [1:0] sz, input bit sg,
                         input bit [14:0] a, input bit [31:0] wd);
      exp_t      e;
      bit [14:0] ea;
      bit [31:0] v;
      bit        mis, trap;
      int        nb, n;
      nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis  = (a & 15'(nb - 1)) != 15'd0;
      trap = TRAP && mis;
      ea   = a & ~15'(nb - 1);
      e    = '0;
      if (trap) begin
         e.er  = 1'b1;
         e.lat = 4'd1;
      end else if (w) begin
         for (int k = 0; k < nb; k++) rmem[int'(ea) + k] = wd[8*k +: 8];
         e.lat = (nb == 4) ? 4'd2 : 4'd4;
         e.nwr = 4'd1;
         e.wa  = ea[14:2];
      end else begin
         v = '0;
         for (int k = 0; k < nb; k++) v[8*k +: 8] = rmem[int'(ea) + k];
         if (sg && v[8*nb-1])
            for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
         e.rd  = v;
         e.lat = 4'd3;
      end
      exp_q.push_back(e);
      @(posedge clock); #1;
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      n = 0;
      do begin @(negedge clock); n++; end while (!req_ready && n < 50);
      @(posedge clock); #1;
      req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clock); n++; end
      if (exp_q.size() != 0) begin
         chk("rsp_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
         active = 1'b0;
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_rsp_error"}, {31'd0, rsp_error}, 32'd0);
      chk({tag, "_dmem_addr"}, {19'd0, dmem_address}, 32'd0);
      chk({tag, "_dmem_din"}, dmem_data_in, 32'd0);
      chk({tag, "_dmem_rw"}, {31'd0, dmem_read_write}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      #12;
      chk_reset_outs("reset");
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // word store / load round trip
      do_req(1'b1, 2'd2, 1'b0, 15'h0000, 32'hA5A5_A5A5);
      do_req(1'b0, 2'd2, 1'b0, 15'h0000, 32'h0);
      chk("tp_word_load", last_rdata, 32'hA5A5_A5A5);

      // byte lanes in bank 1, word 4
      do_req(1'b1, 2'd2, 1'b0, 15'h1010, 32'h1234_5678);
      do_req(1'b0, 2'd0, 1'b1, 15'h1011, 32'h0);
      chk("tp_sbyte_56", last_rdata, 32'h0000_0056);
      do_req(1'b1, 2'd0, 1'b1, 15'h1011, 32'h0000_0080);
      do_req(1'b0, 2'd2, 1'b0, 15'h1010, 32'h0);
      chk("tp_after_bstore", last_rdata, 32'h1234_8078);
      do_req(1'b0, 2'd0, 1'b1, 15'h1011, 32'h0);
      chk("tp_sbyte_80", last_rdata, 32'hFFFF_FF80);

      // halfword merge in bank 2, word 8
      do_req(1'b1, 2'd2, 1'b0, 15'h2020, 32'h1532_8054);
      do_req(1'b1, 2'd1, 1'b0, 15'h2022, 32'h0000_BEEF);
      do_req(1'b0, 2'd2, 1'b0, 15'h2020, 32'h0);
      chk("tp_half_merge", last_rdata, 32'hBEEF_8054);
      do_req(1'b0, 2'd1, 1'b0, 15'h2022, 32'h0);
      chk("tp_uhalf", last_rdata, 32'h0000_BEEF);

      // backpressure: response must hold for 5 cycles
      rr_mode = 2;
      do_req(1'b0, 2'd2, 1'b0, 15'h2020, 32'h0);
      chk("tp_hold", last_rdata, 32'hBEEF_8054);
      rr_mode = 0;

      // reset while a byte store sits in CAP
      @(posedge clock); #1;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 15'h1010; req_wdata = 32'h0000_0033;
      @(negedge clock);
      chk("rst_accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk_reset_outs("midrst");
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (4) begin
         @(negedge clock);
         chk("midrst_no_wr", {31'd0, dmem_read_write}, 32'd0);
      end
      do_req(1'b0, 2'd2, 1'b0, 15'h1010, 32'h0);
      chk("midrst_dropped", last_rdata, 32'h1234_8078);

      // misaligned word load
      do_req(1'b1, 2'd2, 1'b0, 15'h7030, 32'hCAFE_F00D);
      do_req(1'b0, 2'd2, 1'b0, 15'h7032, 32'h0);
      chk("mis_err", {31'd0, last_err}, {31'd0, TRAP});
      chk("mis_rdata", last_rdata, TRAP ? 32'h0 : 32'hCAFE_F00D);

      // random traffic over a small pool of words in every bank
      rr_mode = 1;
      for (int i = 0; i < 250; i++) begin
         bit [14:0] a;
         a = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clock);
      end
      rr_mode = 0;
      repeat (3) @(posedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting directly upstream of the data memory (DMEM_TopLevel). It accepts byte, halfword and word requests from the execute stage over a valid/ready handshake and converts them into DMEM word accesses: 13-bit word address, 32-bit data, single read_write strobe. Loads are extracted from the read word and optionally sign-extended. Sub-word stores are performed as read-modify-write.

## Interface
- `ADDR_W`, 15: byte address width. The word address is bits [14:2]; [14:12] selects the bank, [11:2] selects the word.
- `DATA_W`, 32: data width; fixed at 32.
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_signed`  in  1  sign-extend loads.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present; held until accepted.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  32  load result; 0 for stores.
- `rsp_error`  out  1  misaligned access (see Configuration).
- `dmem_address`  out  13  to DMEM `address`.
- `dmem_data_in`  out  32  to DMEM `data_in`.
- `dmem_read_write`  out  1  to DMEM `read_write`; 1 = write, 0 = read.
- `dmem_dataOut`  in  32  from DMEM `dataOut`.

## Operation
- Byte order is little-endian. Lane = `req_addr[1:0]`; halfword lane = `req_addr[1]`.
- FSM states: IDLE, RD, CAP, WR, RESP.
- IDLE:
  - Latch the request on `req_valid && req_ready`.
  - Word store goes to WR; every other request goes to RD.
- RD: drive `dmem_address`, `dmem_read_write=0`.
- CAP: sample `dmem_dataOut`.
  - Load: extract the lane and zero/sign-extend it into `rsp_rdata`, then go to RESP.
  - Sub-word store: merge `req_wdata` into the selected lane(s) of the read word, then go to WR.
- WR: drive `dmem_read_write=1` and `dmem_data_in` (merged word or full word) for exactly one cycle, then go to RESP.
- RESP: assert `rsp_valid`. On `rsp_ready`, go to IDLE.
- `dmem_read_write` is 0 in every state except WR.
- `dmem_address` holds the latched word address from acceptance until the return to IDLE.
- Only one request is in flight at a time. A new `req_valid` arriving during RESP is not accepted until the next IDLE cycle.
- Reset values:
  - state = IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_error=0`.
  - `dmem_address=0`, `dmem_data_in=0`, `dmem_read_write=0`.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and the in-flight request is dropped with no response.
  - A write in WR when reset is asserted is deasserted asynchronously; commit of that write is not guaranteed.

## Timing
- DMEM read latency is one cycle: the address is presented in RD and `dmem_dataOut` is valid in CAP.
- Cycles from acceptance edge to first `rsp_valid` cycle:
  - word store: 2 (WR, RESP)
  - load: 3 (RD, CAP, RESP)
  - sub-word store: 4 (RD, CAP, WR, RESP)
- With `rsp_ready` tied high, throughput is one request per latency+1 cycles.
- `rsp_rdata` and `rsp_error` are stable for the whole time `rsp_valid` is high.

## Configuration
- `DMEM_LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]=1`, or a word access with `addr[1:0]!=0`, goes from IDLE straight to RESP with `rsp_error=1` and `rsp_rdata=0`.
  - DMEM is not accessed.
- Undefined:
  - Low address bits are forced to the natural alignment (half: clear bit 0; word: clear bits [1:0]).
  - `rsp_error` is tied to 0.

## Structure
- Package `dmem_lsu_pkg` holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum
  - DMEM_ADDR_W=13, BANK_W=3
- Sub-module `dmem_lsu_align` (combinational):
  - load lane extract plus sign/zero extension
  - store lane merge
  - instantiated once.

## Test plan
- Word store 0xA5A5A5A5 to byte address 0x0000, then word load from 0x0000:
  - store: exactly one `dmem_read_write=1` cycle with `dmem_address=0`.
  - load: `rsp_rdata=0xA5A5A5A5` three cycles after acceptance.
- Store word 0x12345678 to 0x1010 (bank 1, word 4), then signed byte load at 0x1011 -> `rsp_rdata=0x00000056`. Signed byte store 0x80 to 0x1011, then reload -> word reads 0x12348078 and signed byte load returns 0xFFFFFF80.
- Halfword store 0xBEEF to 0x2022 over 0x15328054 (bank 2, word 8) -> word becomes 0xBEEF8054. Unsigned half load at 0x2022 -> 0x0000BEEF.
- Hold `rsp_ready=0` for 5 cycles after a load -> `rsp_valid` and `rsp_rdata` stay stable, `req_ready` stays 0, and no DMEM write occurs.
- Assert `reset` during the CAP state of a sub-word store -> all outputs return to their reset values immediately, no WR cycle follows, and the next request completes normally.
- Word load at 0x7032, with and without `DMEM_LSU_MISALIGN_TRAP_EN`:
  - with: `rsp_error=1` one cycle after acceptance, and no DMEM read is issued.
  - without: the load reads word address 0x7030 (bank 7, word 12), `rsp_error=0`.
